// File: rtl/calc_pkg.sv
// Shared definitions for the calculator input path and the LCD UI:
// token codes, FSM state encoding, and the arithmetic evaluator.
package calc_pkg;

  localparam logic [3:0] POS_MAX   = 4'd13;
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  localparam logic [3:0] TOK_ADD = 4'd10;
  localparam logic [3:0] TOK_SUB = 4'd11;
  localparam logic [3:0] TOK_MUL = 4'd12;
  localparam logic [3:0] TOK_DIV = 4'd13;

  localparam logic [1:0] ST_GET_A  = 2'd0;
  localparam logic [1:0] ST_GET_OP = 2'd1;
  localparam logic [1:0] ST_GET_B  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef struct packed {
    logic [7:0] result;
    logic       div_err;
  } calc_res_t;

  function automatic logic is_digit(input logic [3:0] tok);
    return tok <= DIGIT_MAX;
  endfunction

  // Operands are 0..9, so every result fits in signed 8 bits (-9..81).
  function automatic calc_res_t calc_eval(input logic [3:0] a,
                                          input logic [3:0] b,
                                          input logic [3:0] op);
    calc_res_t  res;
    logic [7:0] wa;
    logic [7:0] wb;
    res.result  = 8'd0;
    res.div_err = 1'b0;
    wa = {4'd0, a};
    wb = {4'd0, b};
    case (op)
      TOK_ADD: res.result = wa + wb;
      TOK_SUB: res.result = wa - wb;
      TOK_MUL: res.result = wa * wb;
      TOK_DIV: begin
        // Both operands are non-negative, so unsigned division truncates toward zero.
        if (b == 4'd0) res.div_err = 1'b1;
        else           res.result  = {4'd0, a / b};
      end
      default: res.result = 8'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioning: 2-flop synchroniser, counter debouncer and
// rising-edge detector producing a single-cycle press event.
module btn_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic rise
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_q;
  logic [CNT_W-1:0] cnt;

  // NOTE: all state below uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // The level flips on the DEB_CYCLES-th consecutive differing cycle; any
  // agreeing cycle in between restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync2 != level) begin
      if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= 1'b0;
    else        level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/calc_input_ctrl.sv
// Three-button calculator front end: cursor over the token strip, token
// acceptance FSM (A op B) and registered result for the LCD UI.
module calc_input_ctrl
  import calc_pkg::*;
#(
  parameter int DEB_CYCLES = 500000
) (
  input  logic       CLK_50M,
  input  logic       reset_n,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_ok,
  output logic [3:0] pos,
  output logic [3:0] show,
  output logic       comf,
  output logic       sf,
  output logic [7:0] result,
  output logic       div_err
);

  logic       ev_left;
  logic       ev_right;
  logic       ev_ok;
  logic [1:0] state;
  logic [3:0] a;
  logic [3:0] op;
  logic       tok_digit;
  logic       accept;
  calc_res_t  calc;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left (
    .clk   (CLK_50M),
    .rst_n (reset_n),
    .raw   (btn_left),
    .rise  (ev_left)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right (
    .clk   (CLK_50M),
    .rst_n (reset_n),
    .raw   (btn_right),
    .rise  (ev_right)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ok (
    .clk   (CLK_50M),
    .rst_n (reset_n),
    .raw   (btn_ok),
    .rise  (ev_ok)
  );

  // Opposing moves in the same cycle cancel out.
  always_ff @(posedge CLK_50M or negedge reset_n) begin
    if (!reset_n) begin
      pos <= 4'd0;
    end else begin
      case ({ev_left, ev_right})
        2'b10:   if (pos != 4'd0)  pos <= pos - 4'd1;
        2'b01:   if (pos != POS_MAX) pos <= pos + 4'd1;
        default: pos <= pos;
      endcase
    end
  end

  // NOTE: defaults first in always_comb so no path leaves a signal unassigned
  // and infers a latch.
  always_comb begin
    tok_digit = is_digit(pos);
    accept    = 1'b0;
    calc      = calc_eval(a, pos, op);
    if (ev_ok) begin
      case (state)
        ST_GET_OP, ST_GET_B: accept = 1'b1;
        default:             accept = tok_digit;
      endcase
    end
  end

  // pos is read before its own update this cycle, so an ok coinciding with a
  // move evaluates the pre-move token. Operand B goes straight into result.
  always_ff @(posedge CLK_50M or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_GET_A;
      a       <= 4'd0;
      op      <= TOK_ADD;
      show    <= 4'd0;
      comf    <= 1'b0;
      sf      <= 1'b0;
      result  <= 8'd0;
      div_err <= 1'b0;
    end else begin
      comf <= accept;
      if (accept) show <= pos;
      if (ev_ok) begin
        case (state)
          ST_GET_A: begin
            if (tok_digit) begin
              a     <= pos;
              state <= ST_GET_OP;
            end
          end
          ST_GET_OP: begin
            if (tok_digit) begin
              a <= pos;
            end else begin
              op    <= pos;
              state <= ST_GET_B;
            end
          end
          ST_GET_B: begin
            if (tok_digit) begin
              result  <= calc.result;
              div_err <= calc.div_err;
              sf      <= 1'b1;
              state   <= ST_DONE;
            end else begin
              op <= pos;
            end
          end
          default: begin
            if (tok_digit) begin
              sf      <= 1'b0;
              div_err <= 1'b0;
              a       <= pos;
              state   <= ST_GET_OP;
            end
          end
        endcase
      end
    end
  end

endmodule
